// File: rtl/lcd_8080_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_8080_if
// Brief    : Window request, pixel stream and 8080 bus-word bundle for the
//            LCD controller. The controller takes the slave view; the host /
//            bus driver side takes the master view.
// Revision : 1.0 - initial release
// ============================================================================
interface lcd_8080_if;
    logic        win_start;
    logic [9:0]  win_x0;
    logic [9:0]  win_x1;
    logic [9:0]  win_y0;
    logic [9:0]  win_y1;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_ready;
    logic        app_valid;
    logic [16:0] app_din;
    logic        ready;
    logic        done;
    logic        err;

    modport master (
        output win_start, win_x0, win_x1, win_y0, win_y1, pix_valid, pix_data,
        input  pix_ready, app_valid, app_din, ready, done, err
    );

    modport slave (
        input  win_start, win_x0, win_x1, win_y0, win_y1, pix_valid, pix_data,
        output pix_ready, app_valid, app_din, ready, done, err
    );
endinterface
`default_nettype wire

// File: rtl/lcd_8080_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lcd_8080_ctrl
// Brief    : Power-up sequencer (SLPOUT / DISPON) and window writer for an
//            8080-style LCD. Emits CASET/PASET/RAMWR headers followed by the
//            RGB565 pixel stream, one registered bus word per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_8080_ctrl #(
    parameter int INIT_DELAY = 6000000,
    parameter int SLP_DELAY  = 6000000
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    lcd_8080_if.slave   bus
);

    typedef enum logic [2:0] {
        RST_WAIT = 3'd0,
        SLPOUT   = 3'd1,
        SLP_WAIT = 3'd2,
        DISPON   = 3'd3,
        IDLE     = 3'd4,
        HDR      = 3'd5,
        PIXEL    = 3'd6,
        DONE     = 3'd7
    } state_t;

    localparam logic [31:0] c_INIT_LAST = 32'(INIT_DELAY - 1);
    localparam logic [31:0] c_SLP_LAST  = 32'(SLP_DELAY - 1);
    localparam logic [3:0]  c_HDR_LAST  = 4'd10;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_dly;
    logic [31:0] w_dly_nxt;
    // A full 1024x1024 window is 2^20 pixels, which needs bit 20.
    logic [20:0] r_pix_cnt;
    logic [20:0] w_pix_cnt_nxt;
    logic [3:0]  r_idx;
    logic [3:0]  w_idx_nxt;
    logic [3:0]  w_idx_inc;
    logic [9:0]  r_x0, r_x1, r_y0, r_y1;
    logic        w_latch;
    logic        w_win_ok;
    logic [10:0] w_width;
    logic [10:0] w_height;
    logic [20:0] w_area;
    logic [16:0] w_hdr_word;

    logic        r_app_valid;
    logic [16:0] r_app_din;
    logic        r_pix_ready;
    logic        r_ready;
    logic        r_done;
    logic        r_err;
    logic        w_app_valid_nxt;
    logic [16:0] w_app_din_nxt;
    logic        w_err_nxt;

    assign w_win_ok  = (bus.win_x0 <= bus.win_x1) && (bus.win_y0 <= bus.win_y1);
    assign w_width   = {1'b0, bus.win_x1} - {1'b0, bus.win_x0} + 11'd1;
    assign w_height  = {1'b0, bus.win_y1} - {1'b0, bus.win_y0} + 11'd1;
    assign w_area    = 21'(w_width) * 21'(w_height);
    assign w_idx_inc = r_idx + 4'd1;

    // Header word that follows the one currently on the bus (index r_idx).
    always_comb begin
        w_hdr_word = 17'h0002C;
        case (w_idx_inc)
            4'd1:    w_hdr_word = {1'b1, 14'd0, r_x0[9:8]};
            4'd2:    w_hdr_word = {1'b1, 8'd0,  r_x0[7:0]};
            4'd3:    w_hdr_word = {1'b1, 14'd0, r_x1[9:8]};
            4'd4:    w_hdr_word = {1'b1, 8'd0,  r_x1[7:0]};
            4'd5:    w_hdr_word = 17'h0002B;
            4'd6:    w_hdr_word = {1'b1, 14'd0, r_y0[9:8]};
            4'd7:    w_hdr_word = {1'b1, 8'd0,  r_y0[7:0]};
            4'd8:    w_hdr_word = {1'b1, 14'd0, r_y1[9:8]};
            4'd9:    w_hdr_word = {1'b1, 8'd0,  r_y1[7:0]};
            default: w_hdr_word = 17'h0002C;
        endcase
    end

    // State register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RST_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the bus word to present in the next cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_dly_nxt       = r_dly;
        w_pix_cnt_nxt   = r_pix_cnt;
        w_idx_nxt       = r_idx;
        w_latch         = 1'b0;
        w_app_valid_nxt = 1'b0;
        w_app_din_nxt   = r_app_din;
        w_err_nxt       = 1'b0;
        case (r_state)
            RST_WAIT: begin
                if (r_dly == c_INIT_LAST) begin
                    w_dly_nxt       = '0;
                    w_state_nxt     = SLPOUT;
                    w_app_valid_nxt = 1'b1;
                    w_app_din_nxt   = 17'h00011;
                end else begin
                    w_dly_nxt = r_dly + 32'd1;
                end
            end
            SLPOUT: begin
                w_dly_nxt   = '0;
                w_state_nxt = SLP_WAIT;
            end
            SLP_WAIT: begin
                if (r_dly == c_SLP_LAST) begin
                    w_dly_nxt       = '0;
                    w_state_nxt     = DISPON;
                    w_app_valid_nxt = 1'b1;
                    w_app_din_nxt   = 17'h00029;
                end else begin
                    w_dly_nxt = r_dly + 32'd1;
                end
            end
            DISPON: begin
                w_state_nxt = IDLE;
            end
            IDLE: begin
                if (bus.win_start) begin
                    if (w_win_ok) begin
                        w_latch         = 1'b1;
                        w_pix_cnt_nxt   = w_area;
                        w_idx_nxt       = '0;
                        w_state_nxt     = HDR;
                        w_app_valid_nxt = 1'b1;
                        w_app_din_nxt   = 17'h0002A;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            HDR: begin
                if (r_idx == c_HDR_LAST) begin
                    w_state_nxt = PIXEL;
                end else begin
                    w_idx_nxt       = w_idx_inc;
                    w_app_valid_nxt = 1'b1;
                    w_app_din_nxt   = w_hdr_word;
                end
            end
            PIXEL: begin
                if (bus.pix_valid) begin
                    w_app_valid_nxt = 1'b1;
                    w_app_din_nxt   = {1'b1, bus.pix_data};
                    w_pix_cnt_nxt   = r_pix_cnt - 21'd1;
                    if (r_pix_cnt == 21'd1) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = RST_WAIT;
            end
        endcase
    end

    // Counters, latched window bounds and all registered outputs.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly       <= '0;
            r_pix_cnt   <= '0;
            r_idx       <= '0;
            r_x0        <= '0;
            r_x1        <= '0;
            r_y0        <= '0;
            r_y1        <= '0;
            r_app_valid <= 1'b0;
            r_app_din   <= '0;
            r_pix_ready <= 1'b0;
            r_ready     <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_dly       <= w_dly_nxt;
            r_pix_cnt   <= w_pix_cnt_nxt;
            r_idx       <= w_idx_nxt;
            if (w_latch) begin
                r_x0 <= bus.win_x0;
                r_x1 <= bus.win_x1;
                r_y0 <= bus.win_y0;
                r_y1 <= bus.win_y1;
            end
            r_app_valid <= w_app_valid_nxt;
            r_app_din   <= w_app_din_nxt;
            r_err       <= w_err_nxt;
            // Status flags are decoded from the upcoming state so they line
            // up with the state itself while still coming from a flop.
            r_pix_ready <= (w_state_nxt == PIXEL);
            r_ready     <= (w_state_nxt == IDLE);
            r_done      <= (w_state_nxt == DONE);
        end
    end

    assign bus.app_valid = r_app_valid;
    assign bus.app_din   = r_app_din;
    assign bus.pix_ready = r_pix_ready;
    assign bus.ready     = r_ready;
    assign bus.done      = r_done;
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_lcd_8080_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_8080_ctrl
// Brief    : Self-checking bench for lcd_8080_ctrl. Expected bus words are
//            time-stamped from the window/pixel rules and compared against a
//            monitor capture of every app_valid cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_8080_ctrl;

    localparam int INIT_DELAY = 4;
    localparam int SLP_DELAY  = 4;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;

    lcd_8080_if bus ();

    lcd_8080_ctrl #(
        .INIT_DELAY (INIT_DELAY),
        .SLP_DELAY  (SLP_DELAY)
    ) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          obs_cyc[$];
    logic [16:0] obs_word[$];
    int          exp_cyc[$];
    logic [16:0] exp_word[$];
    logic [15:0] pix_src[$];
    int          done_cnt = 0;
    int          err_cnt  = 0;
    int          exp_done = 0;
    int          exp_err  = 0;

    // Capture every bus word with the cycle it was visible in.
    always @(negedge sys_clk) begin
        if (bus.app_valid) begin
            obs_cyc.push_back(cyc);
            obs_word.push_back(bus.app_din);
        end
        if (bus.done) done_cnt <= done_cnt + 1;
        if (bus.err)  err_cnt  <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, want);
        end
    endtask

    task automatic expect_word(input int c, input logic [16:0] w);
        exp_cyc.push_back(c);
        exp_word.push_back(w);
    endtask

    task automatic compare_sb(input string tag);
        #1;
        check({tag, "_len"}, obs_cyc.size(), exp_cyc.size());
        for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
            check({tag, "_cyc"}, obs_cyc[i], exp_cyc[i]);
            check({tag, "_word"}, 32'(obs_word[i]), 32'(exp_word[i]));
        end
        obs_cyc.delete();
        obs_word.delete();
        exp_cyc.delete();
        exp_word.delete();
    endtask

    function automatic logic [31:0] outs_vec();
        return 32'({bus.app_valid, bus.app_din, bus.pix_ready, bus.ready, bus.done, bus.err});
    endfunction

    task automatic wait_ready();
        int g;
        g = 0;
        @(negedge sys_clk);
        while (!bus.ready && g < 200) begin
            @(negedge sys_clk);
            g++;
        end
        check("ready_wait", 32'(bus.ready), 32'd1);
    endtask

    // Called on the negedge where rst_n was released (cyc == rel).
    task automatic do_init(input int rel);
        int t_slp;
        int t_dsp;
        int g;
        t_slp = rel + INIT_DELAY;
        t_dsp = t_slp + 1 + SLP_DELAY;
        expect_word(t_slp, 17'h00011);
        expect_word(t_dsp, 17'h00029);
        g = 0;
        while (cyc < t_dsp && g < 100) begin
            @(negedge sys_clk);
            g++;
        end
        check("ready_during_dispon", 32'(bus.ready), 32'd0);
        @(negedge sys_clk);
        check("ready_after_dispon", 32'(bus.ready), 32'd1);
        compare_sb("init");
    endtask

    task automatic push_header(input int k, input logic [9:0] x0, input logic [9:0] x1,
                               input logic [9:0] y0, input logic [9:0] y1);
        logic [16:0] h [11];
        h[0]  = 17'h0002A;
        h[1]  = 17'h10000 + 17'(x0 / 256);
        h[2]  = 17'h10000 + 17'(x0 % 256);
        h[3]  = 17'h10000 + 17'(x1 / 256);
        h[4]  = 17'h10000 + 17'(x1 % 256);
        h[5]  = 17'h0002B;
        h[6]  = 17'h10000 + 17'(y0 / 256);
        h[7]  = 17'h10000 + 17'(y0 % 256);
        h[8]  = 17'h10000 + 17'(y1 / 256);
        h[9]  = 17'h10000 + 17'(y1 % 256);
        h[10] = 17'h0002C;
        for (int i = 0; i < 11; i++) expect_word(k + i, h[i]);
    endtask

    function automatic logic [15:0] next_pix();
        if (pix_src.size() > 0) return pix_src.pop_front();
        return 16'($urandom);
    endfunction

    // gap < 0: random pix_valid; gap >= 0: fixed number of idle cycles between pixels.
    task automatic run_window(input logic [9:0] x0, input logic [9:0] x1,
                              input logic [9:0] y0, input logic [9:0] y1,
                              input int gap, input bit poke);
        int          k, area, remaining, g, wait_cnt, first_rdy;
        bit          give, poked;
        logic [15:0] d;
        wait_ready();
        bus.win_start = 1'b1;
        bus.win_x0 = x0; bus.win_x1 = x1; bus.win_y0 = y0; bus.win_y1 = y1;
        k = cyc + 1;
        if (x1 < x0 || y1 < y0) begin
            @(negedge sys_clk);
            bus.win_start = 1'b0;
            exp_err++;
            check("reject_err", 32'(bus.err), 32'd1);
            check("reject_ready", 32'(bus.ready), 32'd1);
            check("reject_valid", 32'(bus.app_valid), 32'd0);
            @(negedge sys_clk);
            check("reject_err_clr", 32'(bus.err), 32'd0);
            check("reject_ready2", 32'(bus.ready), 32'd1);
            compare_sb("reject");
            return;
        end
        area = (int'(x1) - int'(x0) + 1) * (int'(y1) - int'(y0) + 1);
        push_header(k, x0, x1, y0, y1);
        remaining = area;
        g = 0; wait_cnt = 0; first_rdy = -1; poked = 1'b0;
        while (remaining > 0 && g < 3000) begin
            @(negedge sys_clk);
            g++;
            bus.win_start = 1'b0;
            if (bus.pix_ready) begin
                if (first_rdy < 0) first_rdy = cyc;
                if (poke && !poked) begin
                    // Bad window while busy: must be ignored without err.
                    poked = 1'b1;
                    bus.win_start = 1'b1;
                    bus.win_x0 = 10'd5;
                    bus.win_x1 = 10'd4;
                end
                give = (gap < 0) ? ($urandom_range(0, 2) != 0) : (wait_cnt == 0);
                if (give) begin
                    d = next_pix();
                    bus.pix_valid = 1'b1;
                    bus.pix_data  = d;
                    expect_word(cyc + 1, {1'b1, d});
                    remaining--;
                    wait_cnt = (gap > 0) ? gap : 0;
                end else begin
                    bus.pix_valid = 1'b0;
                    bus.pix_data  = 16'($urandom);
                    if (wait_cnt > 0) wait_cnt--;
                end
            end else begin
                // Junk while not ready; nothing of it may reach the bus.
                bus.pix_valid = 1'($urandom_range(0, 1));
                bus.pix_data  = 16'($urandom);
            end
        end
        check("pix_timeout", remaining, 0);
        check("first_pix_ready", first_rdy, k + 11);
        @(negedge sys_clk);
        bus.pix_valid = 1'b0;
        bus.win_start = 1'b0;
        exp_done++;
        check("pix_ready_drop", 32'(bus.pix_ready), 32'd0);
        check("done_pulse", 32'(bus.done), 32'd1);
        check("ready_in_done", 32'(bus.ready), 32'd0);
        @(negedge sys_clk);
        check("done_clear", 32'(bus.done), 32'd0);
        check("ready_after_done", 32'(bus.ready), 32'd1);
        compare_sb("win");
    endtask

    task automatic reset_mid_pixel();
        int k, g, rel;
        logic [15:0] d;
        wait_ready();
        bus.win_start = 1'b1;
        bus.win_x0 = 10'd0; bus.win_x1 = 10'd2; bus.win_y0 = 10'd0; bus.win_y1 = 10'd1;
        k = cyc + 1;
        push_header(k, 10'd0, 10'd2, 10'd0, 10'd1);
        g = 0;
        @(negedge sys_clk);
        bus.win_start = 1'b0;
        while (!bus.pix_ready && g < 100) begin
            @(negedge sys_clk);
            g++;
        end
        check("rst_mid_ready_wait", 32'(bus.pix_ready), 32'd1);
        for (int i = 0; i < 2; i++) begin
            d = next_pix();
            bus.pix_valid = 1'b1;
            bus.pix_data  = d;
            expect_word(cyc + 1, {1'b1, d});
            @(negedge sys_clk);
        end
        bus.pix_valid = 1'b1;
        bus.pix_data  = 16'hDEAD;
        #2 rst_n = 1'b0;
        #1 check("rst_mid_outs", outs_vec(), 32'd0);
        bus.pix_valid = 1'b0;
        compare_sb("pre_reset");
        @(negedge sys_clk);
        check("rst_hold_outs", outs_vec(), 32'd0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        rel = cyc;
        do_init(rel);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          w, h, gap, rel;
        logic [9:0]  x0, x1, y0, y1;
        bus.win_start = 1'b0;
        bus.win_x0 = '0; bus.win_x1 = '0; bus.win_y0 = '0; bus.win_y1 = '0;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("reset_outs", outs_vec(), 32'd0);
        rst_n = 1'b1;
        rel = cyc;
        do_init(rel);

        pix_src.push_back(16'h1234);
        pix_src.push_back(16'h5678);
        run_window(10'd0, 10'd1, 10'd0, 10'd0, 0, 1'b0);
        run_window(10'd5, 10'd4, 10'd0, 10'd0, 0, 1'b0);
        run_window(10'd10, 10'd12, 10'd7, 10'd7, 2, 1'b1);
        run_window(10'd298, 10'd300, 10'd0, 10'd1, -1, 1'b0);
        run_window(10'd7, 10'd7, 10'd9, 10'd9, 0, 1'b0);
        run_window(10'd1023, 10'd1023, 10'd1022, 10'd1023, 1, 1'b1);
        run_window(10'd3, 10'd4, 10'd6, 10'd2, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            w  = $urandom_range(1, 4);
            h  = $urandom_range(1, 3);
            x0 = 10'($urandom_range(0, 1024 - w));
            x1 = x0 + 10'(w - 1);
            y0 = 10'($urandom_range(0, 1024 - h));
            y1 = y0 + 10'(h - 1);
            if ($urandom_range(0, 4) == 0 && x0 > 10'd0) x1 = x0 - 10'd1;
            gap = ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, 2));
            run_window(x0, x1, y0, y1, gap, 1'($urandom_range(0, 1)));
        end

        reset_mid_pixel();
        run_window(10'd20, 10'd21, 10'd30, 10'd31, -1, 1'b0);

        @(negedge sys_clk);
        #1;
        check("done_count", done_cnt, exp_done);
        check("err_count", err_cnt, exp_err);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
